// File: rtl/spi_master_ram_if_if.sv
// rtl/spi_master_ram_if_if.sv - command/response bus between host sequencer and spi_master_ram_if
interface spi_master_ram_if_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/spi_master_ram_if.sv
// rtl/spi_master_ram_if.sv - SPI mode-0 master issuing op+payload frames to the SPI-slave/RAM subsystem
// Optional AUTO_READ_EN: a READ_ADD frame is followed automatically by a READ_DATA frame.
module spi_master_ram_if #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_master_ram_if_if.slave  bus,
  output logic                sclk,
  output logic                ss_n,
  output logic                mosi,
  input  logic                miso
);

  localparam int CNT_W      = $clog2(CLK_DIV + 1);
  localparam int FRAME_W    = DATA_W + 2;
  localparam int CMD_HALVES = 2 * FRAME_W;
  localparam int RSP_END    = 2 * (FRAME_W + DATA_W);
  localparam int HALF_W     = $clog2(RSP_END + 2);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_CMD, SHIFT_RSP, HOLD} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    div_cnt, div_cnt_d;
  logic [HALF_W-1:0]   half_cnt, half_cnt_d;
  logic [FRAME_W-1:0]  sr, sr_d;
  logic [DATA_W-1:0]   rx, rx_d;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_d;
  logic                rsp_valid_r, rsp_valid_d;
  logic                is_read, is_read_d;
  logic                auto_pend, auto_d;
  logic                sclk_r, sclk_d;
  logic                ss_n_r, ss_n_d;
  logic                mosi_r, mosi_d;
  logic                tick;

  // One tick per SCLK half-period; the divider only runs while a frame is in flight.
  assign tick = (div_cnt == CNT_W'(CLK_DIV - 1));

  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign sclk          = sclk_r;
  assign ss_n          = ss_n_r;
  assign mosi          = mosi_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      half_cnt    <= '0;
      sr          <= '0;
      rx          <= '0;
      rsp_data_r  <= '0;
      rsp_valid_r <= 1'b0;
      is_read     <= 1'b0;
      auto_pend   <= 1'b0;
      sclk_r      <= 1'b0;
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_d;
      half_cnt    <= half_cnt_d;
      sr          <= sr_d;
      rx          <= rx_d;
      rsp_data_r  <= rsp_data_d;
      rsp_valid_r <= rsp_valid_d;
      is_read     <= is_read_d;
      auto_pend   <= auto_d;
      sclk_r      <= sclk_d;
      ss_n_r      <= ss_n_d;
      mosi_r      <= mosi_d;
    end
  end

  always_comb begin
    state_d     = state;
    div_cnt_d   = (state == IDLE || tick) ? '0 : div_cnt + CNT_W'(1);
    half_cnt_d  = half_cnt;
    sr_d        = sr;
    rx_d        = rx;
    rsp_data_d  = rsp_data_r;
    rsp_valid_d = 1'b0;
    is_read_d   = is_read;
    auto_d      = auto_pend;
    sclk_d      = sclk_r;
    ss_n_d      = ss_n_r;
    mosi_d      = mosi_r;

    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d    = SETUP;
          sr_d       = {bus.cmd_op, bus.cmd_data};
          rx_d       = '0;
          half_cnt_d = '0;
          is_read_d  = (bus.cmd_op == 2'b11);
`ifdef AUTO_READ_EN
          auto_d     = (bus.cmd_op == 2'b10);
`else
          auto_d     = 1'b0;
`endif
          ss_n_d     = 1'b0;
          sclk_d     = 1'b0;
          mosi_d     = bus.cmd_op[1];
        end
      end

      SETUP: begin
        if (tick) begin
          state_d    = SHIFT_CMD;
          half_cnt_d = HALF_W'(1);
          sclk_d     = 1'b1;
        end
      end

      // Odd half_cnt ends a high phase (falling edge); the trailing low half keeps ss_n low one more half.
      SHIFT_CMD: begin
        if (tick) begin
          half_cnt_d = half_cnt + HALF_W'(1);
          if (half_cnt == HALF_W'(CMD_HALVES)) begin
            state_d    = HOLD;
            half_cnt_d = '0;
            sclk_d     = 1'b0;
            ss_n_d     = 1'b1;
            mosi_d     = 1'b0;
          end else if (half_cnt[0]) begin
            sclk_d = 1'b0;
            mosi_d = sr[FRAME_W-2];
            sr_d   = sr << 1;
            if (is_read && half_cnt == HALF_W'(CMD_HALVES - 1)) begin
              state_d = SHIFT_RSP;
            end
          end else begin
            sclk_d = 1'b1;
          end
        end
      end

      SHIFT_RSP: begin
        if (tick) begin
          half_cnt_d = half_cnt + HALF_W'(1);
          if (half_cnt == HALF_W'(RSP_END)) begin
            state_d     = HOLD;
            half_cnt_d  = '0;
            sclk_d      = 1'b0;
            ss_n_d      = 1'b1;
            mosi_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx;
          end else if (!half_cnt[0]) begin
            sclk_d = 1'b1;
            rx_d   = {rx[DATA_W-2:0], miso};
          end else begin
            sclk_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (tick) begin
          if (auto_pend) begin
            state_d   = SETUP;
            sr_d      = {2'b11, {DATA_W{1'b0}}};
            rx_d      = '0;
            is_read_d = 1'b1;
            auto_d    = 1'b0;
            ss_n_d    = 1'b0;
            mosi_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master_ram_if.sv
// tb/tb_spi_master_ram_if.sv - scoreboard bench for spi_master_ram_if at CLK_DIV=2
`timescale 1ns/1ps
module tb_spi_master_ram_if;

  localparam int CLK_DIV = 2;

  typedef struct {
    logic [17:0] bits;
    int          nrise;
    int          low;
    int          min_gap;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sclk, ss_n, mosi;
  logic miso = 1'b0;
  logic [7:0] slave_byte = 8'h00;

  int checks = 0;
  int errors = 0;

  frame_t     frame_q[$];
  logic [7:0] rsp_q[$];

  spi_master_ram_if_if #(.DATA_W(8)) bus_i ();

  spi_master_ram_if #(.CLK_DIV(CLK_DIV), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i),
    .sclk  (sclk),
    .ss_n  (ss_n),
    .mosi  (mosi),
    .miso  (miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min);
    checks++;
    if (act < min) begin
      errors++;
      $display("FAIL %s: got %0d expected >= %0d", name, act, min);
    end
  endtask

  task automatic expect_frame(input logic [1:0] op, input logic [7:0] data, input int min_gap);
    frame_t f;
    f.bits    = {op, data, 8'h00};
    f.nrise   = (op == 2'b11) ? 18 : 10;
    f.low     = (op == 2'b11) ? 37 * CLK_DIV : 21 * CLK_DIV;
    f.min_gap = min_gap;
    frame_q.push_back(f);
    if (op == 2'b11) rsp_q.push_back(slave_byte);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data, input bit do_expect);
    int n;
    if (do_expect) expect_frame(op, data, CLK_DIV + 1);
    @(negedge clk);
    bus_i.cmd_valid = 1'b1;
    bus_i.cmd_op    = op;
    bus_i.cmd_data  = data;
    n = 0;
    while (!bus_i.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("send_ready_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus_i.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus_i.busy || frame_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'd1, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sclk"},      {31'd0, sclk}, 32'd0);
    chk({tag, "_ss_n"},      {31'd0, ss_n}, 32'd1);
    chk({tag, "_mosi"},      {31'd0, mosi}, 32'd0);
    chk({tag, "_cmd_ready"}, {31'd0, bus_i.cmd_ready}, 32'd1);
    chk({tag, "_busy"},      {31'd0, bus_i.busy}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus_i.rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"},  {24'd0, bus_i.rsp_data}, 32'd0);
  endtask

  // Pin monitor plus mode-0 slave: captures mosi on rising sclk, drives miso after falling edges 10..17.
  logic        prev_sclk;
  bit          in_frame;
  int          low_cnt, rise_cnt, fall_cnt, gap_cnt, gap_at_start;
  logic [17:0] cap;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      prev_sclk = 1'b0;
      gap_cnt   = 1000;
      fall_cnt  = 0;
      miso      = 1'b0;
    end else begin
      if (!ss_n) begin
        if (!in_frame) begin
          in_frame     = 1'b1;
          low_cnt      = 0;
          rise_cnt     = 0;
          fall_cnt     = 0;
          cap          = '0;
          gap_at_start = gap_cnt;
        end
        low_cnt++;
        if (sclk && !prev_sclk) begin
          if (rise_cnt < 18) cap[17 - rise_cnt] = mosi;
          rise_cnt++;
        end
        if (!sclk && prev_sclk) begin
          fall_cnt++;
          if (fall_cnt >= 10 && fall_cnt < 18) miso = slave_byte[17 - fall_cnt];
          else miso = 1'b0;
        end
      end else begin
        if (in_frame) begin
          frame_t f;
          in_frame = 1'b0;
          gap_cnt  = 1;
          miso     = 1'b0;
          if (frame_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            f = frame_q.pop_front();
            chk("frame_bits", {14'd0, cap}, {14'd0, f.bits});
            chk("frame_rising_edges", rise_cnt, f.nrise);
            chk("ss_n_low_cycles", low_cnt, f.low);
            chk_ge("ss_n_high_gap", gap_at_start, f.min_gap);
          end
        end else if (gap_cnt < 1000) begin
          gap_cnt++;
        end
      end
      prev_sclk = sclk;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus_i.rsp_valid) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp_valid", 32'd1, 32'd0);
      else chk("rsp_data", {24'd0, bus_i.rsp_data}, {24'd0, rsp_q.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int rises;
    logic ps;
    bus_i.cmd_valid = 1'b0;
    bus_i.cmd_op    = 2'b00;
    bus_i.cmd_data  = 8'h00;

    // Reset values
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // WRITE_ADD A5, no response
    send(2'b00, 8'hA5, 1'b1);
    wait_idle();

    // READ_DATA with slave byte 3C
    slave_byte = 8'h3C;
    send(2'b11, 8'h00, 1'b1);
    wait_idle();
    chk("rsp_data_after_read", {24'd0, bus_i.rsp_data}, 32'h3C);

    // cmd_valid held high across two commands; second payload changes mid-frame of the first
    expect_frame(2'b00, 8'h10, CLK_DIV + 1);
    expect_frame(2'b01, 8'hFF, CLK_DIV + 1);
    @(negedge clk);
    bus_i.cmd_valid = 1'b1;
    bus_i.cmd_op    = 2'b00;
    bus_i.cmd_data  = 8'h10;
    @(negedge clk);
    chk("ready_low_after_accept", {31'd0, bus_i.cmd_ready}, 32'd0);
    bus_i.cmd_op    = 2'b01;
    bus_i.cmd_data  = 8'hFF;
    n = 0;
    while (!bus_i.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("held_ready_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus_i.cmd_valid = 1'b0;
    wait_idle();
    chk("rsp_data_holds", {24'd0, bus_i.rsp_data}, 32'h3C);

    // Reset after the 5th rising sclk of a READ_DATA frame
    slave_byte = 8'h99;
    @(negedge clk);
    bus_i.cmd_valid = 1'b1;
    bus_i.cmd_op    = 2'b11;
    bus_i.cmd_data  = 8'h00;
    @(negedge clk);
    bus_i.cmd_valid = 1'b0;
    rises = 0;
    n = 0;
    ps = sclk;
    while (rises < 5 && n < 500) begin
      @(negedge clk);
      if (sclk && !ps) rises++;
      ps = sclk;
      n++;
    end
    if (n >= 500) chk("fifth_rise_timeout", 32'd1, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send(2'b01, 8'h5A, 1'b1);
    wait_idle();

`ifdef AUTO_READ_EN
    // READ_ADD chains into READ_DATA automatically
    slave_byte = 8'hC3;
    expect_frame(2'b10, 8'h20, CLK_DIV + 1);
    expect_frame(2'b11, 8'h00, CLK_DIV);
    send(2'b10, 8'h20, 1'b0);
    n = 0;
    while (ss_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (!ss_n && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("auto_first_frame_timeout", 32'd1, 32'd0);
    chk("auto_busy_between", {31'd0, bus_i.busy}, 32'd1);
    chk("auto_ready_between", {31'd0, bus_i.cmd_ready}, 32'd0);
    wait_idle();
    chk("auto_rsp_data", {24'd0, bus_i.rsp_data}, 32'hC3);
`else
    // READ_ADD is a plain frame without a response
    slave_byte = 8'hC3;
    send(2'b10, 8'h20, 1'b1);
    wait_idle();
    chk("read_add_no_rsp", {24'd0, bus_i.rsp_data}, 32'h00);
`endif

    chk("frames_outstanding", frame_q.size(), 32'd0);
    chk("rsps_outstanding", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
